// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and flow controller for the five-stage pipeline.
// Tracks in-flight producers in EX/MEM/WB and decides, each cycle, whether
// decode advances, whether a bubble enters EX, and whether fetch/decode is
// redirected by a taken branch or jump. Also drives EX forwarding selects,
// the decode-stage WB bypass, and saturating stall/flush counters.
//
// Parameters:
//   FWD_EN  1 = forward MEM/WB results to EX, 0 = stall on every EX/MEM dependence
//   CNT_W   width of the stall/flush counters
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_*                          decode-stage instruction description
//   pc_write, ifid_write          0 = hold PC / IF-ID register
//   ifid_flush, pc_sel_target     redirect to decode's target and squash IF-ID
//   idex_bubble                   ID/EX loads a NOP
//   fwd_a, fwd_b                  EX operand select (00 reg, 01 MEM ALU, 10 WB)
//   id_byp_a, id_byp_b            decode operand takes WB write data
//   stall_cnt, flush_cnt          saturating event counters
module pipeline_ctrl #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_src,
  input  logic             id_rt_src,
  input  logic             id_wr_reg,
  input  logic             id_is_lw,
  input  logic [4:0]       id_targ_reg,
  input  logic             id_is_beq,
  input  logic             id_is_jump,
  input  logic             id_eq,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_sel_target,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // EX keeps its sources for forwarding; MEM and WB only need what a
  // producer match looks at, so their source fields are not carried.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       is_lw;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_src;
    logic       rt_src;
  } ex_entry_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       is_lw;
    logic [4:0] dst;
  } mem_entry_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] dst;
  } wb_entry_t;

  ex_entry_t      ex_q;
  mem_entry_t     mem_q;
  wb_entry_t      wb_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Register 0 is hard-wired, so it never creates a dependence.
  function automatic logic hit(input logic valid, input logic wr, input logic [4:0] dst,
                               input logic [4:0] src, input logic used);
    return valid & wr & used & (src != 5'd0) & (dst == src);
  endfunction

  logic rs_used, rt_used, ex_dep, mem_dep, load_use, stall, redirect;
  logic mem_to_a, mem_to_b, wb_to_a, wb_to_b;

  // A jump reads no operands, so it can never be held by a dependence.
  assign rs_used = id_rs_src & ~id_is_jump;
  assign rt_used = id_rt_src & ~id_is_jump;

  assign ex_dep  = hit(ex_q.valid, ex_q.wr, ex_q.dst, id_rs, rs_used) |
                   hit(ex_q.valid, ex_q.wr, ex_q.dst, id_rt, rt_used);
  assign mem_dep = hit(mem_q.valid, mem_q.wr, mem_q.dst, id_rs, rs_used) |
                   hit(mem_q.valid, mem_q.wr, mem_q.dst, id_rt, rt_used);
  assign load_use = ex_dep & ex_q.is_lw;

  // Branches compare in decode, which only sees the register file plus the
  // WB bypass, so any EX/MEM producer must drain first.
  assign stall    = id_valid & (load_use | ((~FWD_EN | id_is_beq) & (ex_dep | mem_dep)));
  assign redirect = id_valid & ~stall & (id_is_jump | (id_is_beq & id_eq));

  assign pc_write      = ~stall;
  assign ifid_write    = ~stall;
  assign idex_bubble   = stall;
  assign ifid_flush    = redirect;
  assign pc_sel_target = redirect;

  // A load in MEM has no ALU result worth forwarding; load-use stalls cover it.
  assign mem_to_a = hit(mem_q.valid, mem_q.wr, mem_q.dst, ex_q.rs, ex_q.valid & ex_q.rs_src) &
                    ~mem_q.is_lw;
  assign mem_to_b = hit(mem_q.valid, mem_q.wr, mem_q.dst, ex_q.rt, ex_q.valid & ex_q.rt_src) &
                    ~mem_q.is_lw;
  assign wb_to_a  = hit(wb_q.valid, wb_q.wr, wb_q.dst, ex_q.rs, ex_q.valid & ex_q.rs_src);
  assign wb_to_b  = hit(wb_q.valid, wb_q.wr, wb_q.dst, ex_q.rt, ex_q.valid & ex_q.rt_src);

  assign fwd_a = !FWD_EN ? 2'b00 : mem_to_a ? 2'b01 : wb_to_a ? 2'b10 : 2'b00;
  assign fwd_b = !FWD_EN ? 2'b00 : mem_to_b ? 2'b01 : wb_to_b ? 2'b10 : 2'b00;

  // The register file write is not visible to a same-cycle read.
  assign id_byp_a = hit(wb_q.valid, wb_q.wr, wb_q.dst, id_rs, id_rs_src);
  assign id_byp_b = hit(wb_q.valid, wb_q.wr, wb_q.dst, id_rt, id_rt_src);

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q.valid  <= id_valid & ~stall;
      ex_q.wr     <= id_wr_reg;
      ex_q.is_lw  <= id_is_lw;
      ex_q.dst    <= id_targ_reg;
      ex_q.rs     <= id_rs;
      ex_q.rt     <= id_rt;
      ex_q.rs_src <= rs_used;
      ex_q.rt_src <= rt_used;
      mem_q.valid <= ex_q.valid;
      mem_q.wr    <= ex_q.wr;
      mem_q.is_lw <= ex_q.is_lw;
      mem_q.dst   <= ex_q.dst;
      wb_q.valid  <= mem_q.valid;
      wb_q.wr     <= mem_q.wr;
      wb_q.dst    <= mem_q.dst;
      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: one instance with forwarding (16-bit counters) and
// one without (4-bit counters so saturation is reached), sharing decode inputs.
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_rs_src, id_rt_src, id_wr_reg, id_is_lw, id_is_beq, id_is_jump, id_eq;
  logic [4:0] id_rs, id_rt, id_targ_reg;

  logic       a_pc_write, a_ifid_write, a_ifid_flush, a_pc_sel, a_bubble, a_byp_a, a_byp_b;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic       b_pc_write, b_ifid_write, b_ifid_flush, b_pc_sel, b_bubble, b_byp_a, b_byp_b;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [3:0] b_stall_cnt, b_flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_src(id_rs_src), .id_rt_src(id_rt_src), .id_wr_reg(id_wr_reg), .id_is_lw(id_is_lw),
    .id_targ_reg(id_targ_reg), .id_is_beq(id_is_beq), .id_is_jump(id_is_jump), .id_eq(id_eq),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .pc_sel_target(a_pc_sel), .idex_bubble(a_bubble), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .id_byp_a(a_byp_a), .id_byp_b(a_byp_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_src(id_rs_src), .id_rt_src(id_rt_src), .id_wr_reg(id_wr_reg), .id_is_lw(id_is_lw),
    .id_targ_reg(id_targ_reg), .id_is_beq(id_is_beq), .id_is_jump(id_is_jump), .id_eq(id_eq),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .pc_sel_target(b_pc_sel), .idex_bubble(b_bubble), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .id_byp_a(b_byp_a), .id_byp_b(b_byp_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // ---------------- reference model ----------------
  // In-flight instructions ordered by age: [0] one stage past decode (EX),
  // [1] two stages (MEM), [2] three stages (WB).
  typedef struct packed {
    bit v; bit wr; bit lw; bit [4:0] dst; bit [4:0] rs; bit [4:0] rt; bit rs_u; bit rt_u;
  } ins_t;
  typedef ins_t pipe_t [3];

  pipe_t pa, pb;
  int    sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;
  ins_t  n_ins;
  bit    sa, ra, sb, rb;

  function automatic bit writes(input ins_t e, input logic [4:0] r, input bit used);
    return e.v && e.wr && used && r != 5'd0 && e.dst == r;
  endfunction

  function automatic bit m_stall(input pipe_t p, input bit fe);
    bit ua, ub;
    ua = id_rs_src && !id_is_jump;
    ub = id_rt_src && !id_is_jump;
    if (!id_valid) return 1'b0;
    for (int age = 0; age < 2; age++)
      if (writes(p[age], id_rs, ua) || writes(p[age], id_rt, ub))
        if ((age == 0 && p[age].lw) || !fe || id_is_beq) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_redirect(input pipe_t p, input bit fe);
    return !m_stall(p, fe) && id_valid && (id_is_jump || (id_is_beq && id_eq));
  endfunction

  function automatic bit [1:0] exp_fwd(input pipe_t p, input logic [4:0] r, input bit used,
                                       input bit fe);
    if (!fe || !p[0].v) return 2'd0;
    if (writes(p[1], r, used) && !p[1].lw) return 2'd1;
    if (writes(p[2], r, used)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [10:0] exp_ctrl(input pipe_t p, input bit fe);
    bit s, r;
    s = m_stall(p, fe);
    r = m_redirect(p, fe);
    return {!s, !s, r, r, s, exp_fwd(p, p[0].rs, p[0].rs_u, fe),
            exp_fwd(p, p[0].rt, p[0].rt_u, fe),
            writes(p[2], id_rs, id_rs_src), writes(p[2], id_rt, id_rt_src)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pa[i] = '0;
        pb[i] = '0;
      end
      sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
    end else begin
      sa = m_stall(pa, 1'b1);
      ra = m_redirect(pa, 1'b1);
      sb = m_stall(pb, 1'b0);
      rb = m_redirect(pb, 1'b0);
      if (sa && sc_a < 65535) sc_a++;
      if (ra && fc_a < 65535) fc_a++;
      if (sb && sc_b < 15) sc_b++;
      if (rb && fc_b < 15) fc_b++;
      n_ins = {id_valid, id_wr_reg, id_is_lw, id_targ_reg, id_rs, id_rt,
               id_rs_src && !id_is_jump, id_rt_src && !id_is_jump};
      pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = n_ins; pa[0].v = n_ins.v && !sa;
      pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = n_ins; pb[0].v = n_ins.v && !sb;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ctrl_fwd", 32'({a_pc_write, a_ifid_write, a_ifid_flush, a_pc_sel, a_bubble,
                         a_fwd_a, a_fwd_b, a_byp_a, a_byp_b}), 32'(exp_ctrl(pa, 1'b1)));
    chk("ctrl_nofwd", 32'({b_pc_write, b_ifid_write, b_ifid_flush, b_pc_sel, b_bubble,
                           b_fwd_a, b_fwd_b, b_byp_a, b_byp_b}), 32'(exp_ctrl(pb, 1'b0)));
    chk("stall_cnt_fwd", 32'(a_stall_cnt), sc_a);
    chk("flush_cnt_fwd", 32'(a_flush_cnt), fc_a);
    chk("stall_cnt_nofwd", 32'(b_stall_cnt), sc_b);
    chk("flush_cnt_nofwd", 32'(b_flush_cnt), fc_b);
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit v, input bit wr, input bit lw, input logic [4:0] dst,
                        input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                        input bit rtu, input bit beq, input bit jmp, input bit eq);
    id_valid = v; id_wr_reg = wr; id_is_lw = lw; id_targ_reg = dst;
    id_rs = rs; id_rs_src = rsu; id_rt = rt; id_rt_src = rtu;
    id_is_beq = beq; id_is_jump = jmp; id_eq = eq;
  endtask

  task automatic nop_in();
    set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop_in();
    repeat (3) step();
  endtask

  localparam logic [10:0] CtrlReset = 11'b110_0000_0000;

  initial begin
    int n;
    int k;
    nop_in();
    repeat (3) step();
    chk("reset_ctrl", 32'({a_pc_write, a_ifid_write, a_ifid_flush, a_pc_sel, a_bubble,
                           a_fwd_a, a_fwd_b, a_byp_a, a_byp_b}), 32'(CtrlReset));
    chk("reset_cnt", 32'({a_stall_cnt, a_flush_cnt}), 32'd0);
    rst = 1'b0;
    step();

    // add r3 then sub r3: forwarded from MEM
    set_in(1, 1, 0, 5'd3, 5'd1, 1, 5'd2, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd8, 5'd3, 1, 5'd1, 1, 0, 0, 0); #1;
    chk("alu_dep_no_stall", 32'(a_pc_write), 32'd1);
    step(); nop_in(); #1;
    chk("fwd_from_mem", 32'(a_fwd_a), 32'd1);
    // add r3, unrelated, sub r3: forwarded from WB
    set_in(1, 1, 0, 5'd3, 5'd1, 1, 5'd2, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd9, 5'd10, 1, 5'd11, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd8, 5'd3, 1, 5'd1, 1, 0, 0, 0); step();
    nop_in(); #1;
    chk("fwd_from_wb", 32'(a_fwd_a), 32'd2);
    drain();

    // lw r5 then add r5: one stall, then WB forwarding
    set_in(1, 1, 1, 5'd5, 5'd1, 1, 5'd0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd6, 5'd5, 1, 5'd1, 1, 0, 0, 0); #1;
    chk("load_use_stall", 32'({a_pc_write, a_bubble}), 32'b01);
    step(); #1;
    chk("load_use_release", 32'({a_pc_write, a_bubble}), 32'b10);
    chk("load_use_cnt", 32'(a_stall_cnt), 32'd1);
    step(); nop_in(); #1;
    chk("load_use_fwd", 32'(a_fwd_a), 32'd2);
    drain();

    // add r4 then beq r4,r4 taken: two stalls then redirect
    set_in(1, 1, 0, 5'd4, 5'd1, 1, 5'd2, 1, 0, 0, 0); step();
    set_in(1, 0, 0, 5'd0, 5'd4, 1, 5'd4, 1, 1, 0, 1); #1;
    chk("beq_stall1", 32'(a_pc_write), 32'd0);
    step(); #1;
    chk("beq_stall2", 32'(a_pc_write), 32'd0);
    step(); #1;
    chk("beq_redirect", 32'({a_pc_write, a_pc_sel, a_ifid_flush, a_byp_a, a_byp_b}), 32'h1f);
    step(); nop_in(); #1;
    chk("beq_counts", 32'({a_stall_cnt, a_flush_cnt}), {16'd3, 16'd1});
    drain();

    // jump with unused rs matching a load in EX; then r0 traffic
    set_in(1, 1, 1, 5'd7, 5'd1, 1, 5'd0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 5'd0, 5'd7, 0, 5'd0, 0, 0, 1, 0); #1;
    chk("jump_redirect", 32'({a_pc_write, a_pc_sel, a_ifid_flush}), 32'b111);
    step();
    set_in(1, 1, 0, 5'd0, 5'd1, 1, 5'd2, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd9, 5'd0, 1, 5'd0, 1, 0, 0, 0); #1;
    chk("r0_no_stall", 32'({a_pc_write, b_pc_write}), 32'b11);
    step(); nop_in(); #1;
    chk("r0_no_fwd", 32'({a_fwd_a, a_fwd_b}), 32'd0);
    drain();

    // no forwarding: add r6 then read r6 holds decode for two cycles
    set_in(1, 1, 0, 5'd6, 5'd1, 1, 5'd2, 1, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd8, 5'd6, 1, 5'd1, 1, 0, 0, 0); #1;
    n = 0;
    while (b_pc_write == 1'b0 && n < 10) begin
      n++;
      step(); #1;
    end
    chk("nofwd_stall_cycles", n, 32'd2);
    chk("nofwd_release_byp", 32'(b_byp_a), 32'd1);
    step();
    drain();

    // reset while a load-use stall is active
    set_in(1, 1, 1, 5'd2, 5'd1, 1, 5'd0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 5'd3, 5'd2, 1, 5'd1, 1, 0, 0, 0); #1;
    chk("pre_reset_stall", 32'(a_bubble), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({a_pc_write, a_ifid_write, a_ifid_flush, a_pc_sel, a_bubble,
                                 a_fwd_a, a_fwd_b, a_byp_a, a_byp_b}), 32'(CtrlReset));
    chk("async_reset_cnt", 32'({a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt}), 32'd0);
    step();
    rst = 1'b0;
    step();

    // randomized traffic on a small register window to provoke hazards
    repeat (3000) begin
      k = int'($urandom_range(0, 7));
      set_in($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), k == 2,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), k == 0, k == 1,
             1'($urandom_range(0, 1)));
      step();
    end
    nop_in(); #1;
    chk("nofwd_stall_saturated", 32'(b_stall_cnt), 32'hf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
